// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : Default 640x480@60 raster constants and shared decode helper.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int c_coord_w   = 10;
    localparam int c_max_total = 1 << c_coord_w;

    localparam int c_h_active  = 640;
    localparam int c_h_fp      = 16;
    localparam int c_h_sync    = 96;
    localparam int c_h_bp      = 48;
    localparam int c_h_total   = c_h_active + c_h_fp + c_h_sync + c_h_bp;

    localparam int c_v_active  = 480;
    localparam int c_v_fp      = 10;
    localparam int c_v_sync    = 2;
    localparam int c_v_bp      = 33;
    localparam int c_v_total   = c_v_active + c_v_fp + c_v_sync + c_v_bp;

    localparam bit c_sync_pol  = 1'b0;

    // One extra bit so a window ending exactly at 1024 does not truncate to 0.
    function automatic logic in_window(
        input logic [c_coord_w:0] pos,
        input logic [c_coord_w:0] lo,
        input logic [c_coord_w:0] hi
    );
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_wrap_counter.sv
`default_nettype none
// ============================================================================
// Module   : vga_wrap_counter
// Brief    : Modulo-MAX counter advancing on inc, with a wrap flag.
// Revision : 1.0 - initial release
// ============================================================================
module vga_wrap_counter
#(
    parameter int MAX   = 800,
    parameter int WIDTH = 10
) (
    input  logic             clk_25M,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] c_last = WIDTH'(MAX - 1);

    logic [WIDTH-1:0] r_count;

    // wrap is combinational so the next counter stage sees it on the same edge
    assign wrap  = inc && (r_count == c_last);
    assign count = r_count;

    always_ff @(posedge clk_25M or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= wrap ? '0 : r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_gen
// Brief    : Raster timing generator: syncs, active-video, coordinates, strobes.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = c_h_active,
    parameter int H_FP     = c_h_fp,
    parameter int H_SYNC   = c_h_sync,
    parameter int H_BP     = c_h_bp,
    parameter int V_ACTIVE = c_v_active,
    parameter int V_FP     = c_v_fp,
    parameter int V_SYNC   = c_v_sync,
    parameter int V_BP     = c_v_bp,
    parameter bit SYNC_POL = c_sync_pol
) (
    input  logic                 clk_25M,
    input  logic                 rst,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 video_on,
    output logic [c_coord_w-1:0] pixel_x,
    output logic [c_coord_w-1:0] pixel_y,
    output logic                 line_start,
    output logic                 frame_start
);

    localparam int c_cw1         = c_coord_w + 1;
    localparam int c_line_len    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_frame_lines = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [c_coord_w:0] c_h_act_lim  = c_cw1'(H_ACTIVE);
    localparam logic [c_coord_w:0] c_h_sync_lo  = c_cw1'(H_ACTIVE + H_FP);
    localparam logic [c_coord_w:0] c_h_sync_hi  = c_cw1'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_coord_w:0] c_v_act_lim  = c_cw1'(V_ACTIVE);
    localparam logic [c_coord_w:0] c_v_sync_lo  = c_cw1'(V_ACTIVE + V_FP);
    localparam logic [c_coord_w:0] c_v_sync_hi  = c_cw1'(V_ACTIVE + V_FP + V_SYNC);

    if (c_line_len > c_max_total) begin : g_h_total_check
        $fatal(1, "vga_sync_gen: H_TOTAL exceeds counter range");
    end
    if (c_frame_lines > c_max_total) begin : g_v_total_check
        $fatal(1, "vga_sync_gen: V_TOTAL exceeds counter range");
    end

    logic [c_coord_w-1:0] w_h_cnt;
    logic [c_coord_w-1:0] w_v_cnt;
    logic                 w_h_wrap;
    logic                 w_v_wrap_unused;

    vga_wrap_counter #(
        .MAX   (c_line_len),
        .WIDTH (c_coord_w)
    ) u_h_cnt (
        .clk_25M (clk_25M),
        .rst     (rst),
        .inc     (1'b1),
        .count   (w_h_cnt),
        .wrap    (w_h_wrap)
    );

    vga_wrap_counter #(
        .MAX   (c_frame_lines),
        .WIDTH (c_coord_w)
    ) u_v_cnt (
        .clk_25M (clk_25M),
        .rst     (rst),
        .inc     (w_h_wrap),
        .count   (w_v_cnt),
        .wrap    (w_v_wrap_unused)
    );

    logic [c_coord_w:0] w_h_ext;
    logic [c_coord_w:0] w_v_ext;
    logic               w_video_on;
    logic               w_hsync_act;
    logic               w_vsync_act;
    logic               w_line_start;
    logic               w_frame_start;

    assign w_h_ext       = {1'b0, w_h_cnt};
    assign w_v_ext       = {1'b0, w_v_cnt};
    assign w_video_on    = (w_h_ext < c_h_act_lim) && (w_v_ext < c_v_act_lim);
    assign w_hsync_act   = in_window(w_h_ext, c_h_sync_lo, c_h_sync_hi);
    assign w_vsync_act   = in_window(w_v_ext, c_v_sync_lo, c_v_sync_hi);
    assign w_line_start  = (w_h_cnt == '0);
    assign w_frame_start = w_line_start && (w_v_cnt == '0);

    logic                 r_hsync;
    logic                 r_vsync;
    logic                 r_video_on;
    logic [c_coord_w-1:0] r_pixel_x;
    logic [c_coord_w-1:0] r_pixel_y;
    logic                 r_line_start;
    logic                 r_frame_start;

    // Outputs are the decode of the counters one edge earlier, all aligned.
    always_ff @(posedge clk_25M or posedge rst) begin
        if (rst) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_video_on    <= 1'b0;
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= w_hsync_act ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_vsync_act ? SYNC_POL : ~SYNC_POL;
            r_video_on    <= w_video_on;
            r_pixel_x     <= w_h_cnt;
            r_pixel_y     <= w_v_cnt;
            r_line_start  <= w_line_start;
            r_frame_start <= w_frame_start;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign pixel_x     = r_pixel_x;
    assign pixel_y     = r_pixel_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire
